// File: rtl/sech2_lut_arbiter.sv
// Packet-locked round-robin arbiter in front of the shared sech2 LUT pipeline.
// Tags issued beats with the requester index and demuxes results back by tid.
module sech2_lut_arbiter #(
  parameter int N_REQ           = 4,
  parameter int ID_WIDTH        = 2,
  parameter int DATA_WIDTH_DATA = 16,
  parameter int DATA_WIDTH_RSLT = 16,
  parameter int MAX_INFLIGHT    = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [N_REQ*DATA_WIDTH_DATA-1:0]   s_axis_req_tdata,
  input  logic [N_REQ-1:0]                   s_axis_req_tlast,
  input  logic [N_REQ-1:0]                   s_axis_req_tvalid,
  output logic [N_REQ-1:0]                   s_axis_req_tready,
  output logic [DATA_WIDTH_DATA-1:0]         m_axis_lut_tdata,
  output logic                               m_axis_lut_tlast,
  output logic [ID_WIDTH-1:0]                m_axis_lut_tid,
  output logic                               m_axis_lut_tvalid,
  input  logic                               m_axis_lut_tready,
  input  logic [DATA_WIDTH_RSLT-1:0]         s_axis_lut_tdata,
  input  logic                               s_axis_lut_tlast,
  input  logic [ID_WIDTH-1:0]                s_axis_lut_tid,
  input  logic                               s_axis_lut_tvalid,
  output logic                               s_axis_lut_tready,
  output logic [N_REQ*DATA_WIDTH_RSLT-1:0]   m_axis_rslt_tdata,
  output logic [N_REQ-1:0]                   m_axis_rslt_tlast,
  output logic [N_REQ-1:0]                   m_axis_rslt_tvalid,
  input  logic [N_REQ-1:0]                   m_axis_rslt_tready,
  output logic [N_REQ-1:0]                   grant,
  output logic [3:0]                         inflight,
  output logic                               err_bad_id
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                         state, state_nx;
  logic [ID_WIDTH-1:0]            grant_idx, last_grant, pick_idx;
  logic                           pick_found;
  logic [3:0]                     inflight_q;
  logic                           err_q;
  logic                           can_issue, issue_hs, result_hs, bad_id;
  logic [DATA_WIDTH_DATA-1:0]     g_data;
  logic                           g_last, g_valid;
  logic [N_REQ*DATA_WIDTH_RSLT-1:0] hold_data;
  logic [N_REQ-1:0]               hold_last;

  // Round-robin scan starting just after the previous winner, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pick_found && s_axis_req_tvalid[i] &&
            ((int'(last_grant) + k == i) || (int'(last_grant) + k - N_REQ == i))) begin
          pick_found = 1'b1;
          pick_idx   = ID_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    g_data  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    grant   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        g_data  = s_axis_req_tdata[i*DATA_WIDTH_DATA +: DATA_WIDTH_DATA];
        g_last  = s_axis_req_tlast[i];
        g_valid = s_axis_req_tvalid[i];
        grant[i] = (state == LOCKED);
      end
    end
  end

  // The cap compares against the registered count, so a same-cycle return
  // only frees a slot from the following cycle on.
  assign can_issue = (inflight_q < 4'(MAX_INFLIGHT));

  always_comb begin
    s_axis_req_tready = '0;
    m_axis_lut_tdata  = '0;
    m_axis_lut_tlast  = 1'b0;
    m_axis_lut_tid    = '0;
    m_axis_lut_tvalid = 1'b0;
    if (state == LOCKED) begin
      m_axis_lut_tdata  = g_data;
      m_axis_lut_tlast  = g_last;
      m_axis_lut_tid    = grant_idx;
      m_axis_lut_tvalid = g_valid & can_issue;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_idx == ID_WIDTH'(i)) begin
          s_axis_req_tready[i] = m_axis_lut_tready & can_issue;
        end
      end
    end
  end

  assign issue_hs = m_axis_lut_tvalid & m_axis_lut_tready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_found) state_nx = LOCKED;
      LOCKED:  if (issue_hs && g_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= ID_WIDTH'(N_REQ - 1);
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_found) begin
        grant_idx <= pick_idx;
      end
      if (state == LOCKED && issue_hs && g_last) begin
        last_grant <= grant_idx;
      end
    end
  end

  // Tags that name no requester are swallowed so the LUT never stalls on them.
  assign bad_id = ({1'b0, s_axis_lut_tid} >= (ID_WIDTH+1)'(N_REQ));

  always_comb begin
    m_axis_rslt_tvalid = '0;
    m_axis_rslt_tdata  = hold_data;
    m_axis_rslt_tlast  = hold_last;
    s_axis_lut_tready  = 1'b0;
    if (rstn) begin
      if (bad_id) begin
        s_axis_lut_tready = 1'b1;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (s_axis_lut_tid == ID_WIDTH'(i)) begin
            m_axis_rslt_tvalid[i] = s_axis_lut_tvalid;
            s_axis_lut_tready     = m_axis_rslt_tready[i];
            if (s_axis_lut_tvalid) begin
              m_axis_rslt_tdata[i*DATA_WIDTH_RSLT +: DATA_WIDTH_RSLT] = s_axis_lut_tdata;
              m_axis_rslt_tlast[i] = s_axis_lut_tlast;
            end
          end
        end
      end
    end
  end

  assign result_hs = s_axis_lut_tvalid & s_axis_lut_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_data <= '0;
      hold_last <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (s_axis_lut_tvalid && !bad_id && s_axis_lut_tid == ID_WIDTH'(i)) begin
          hold_data[i*DATA_WIDTH_RSLT +: DATA_WIDTH_RSLT] <= s_axis_lut_tdata;
          hold_last[i] <= s_axis_lut_tlast;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case ({issue_hs, result_hs})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
      if (result_hs && bad_id) begin
        err_q <= 1'b1;
      end
    end
  end

  assign inflight   = inflight_q;
  assign err_bad_id = err_q;

endmodule

// File: tb/tb_sech2_lut_arbiter.sv
// Directed bench for sech2_lut_arbiter; the bench plays both the requesters and the LUT.
// A second 3-requester instance covers out-of-range result tags.
module tb_sech2_lut_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last, req_valid, req_ready;
  logic [DW-1:0]   lut_data;
  logic            lut_last, lut_valid, lut_ready;
  logic [1:0]      lut_tid;
  logic [RW-1:0]   res_data;
  logic            res_last, res_valid, res_ready;
  logic [1:0]      res_tid;
  logic [N*RW-1:0] rslt_data;
  logic [N-1:0]    rslt_last, rslt_valid, rslt_ready;
  logic [N-1:0]    grant;
  logic [3:0]      inflight;
  logic            err;

  logic [3*DW-1:0] r3_req_data;
  logic [2:0]      r3_req_last, r3_req_valid, r3_req_ready;
  logic [DW-1:0]   r3_lut_data;
  logic            r3_lut_last, r3_lut_valid, r3_lut_ready;
  logic [1:0]      r3_lut_tid;
  logic [RW-1:0]   r3_res_data;
  logic            r3_res_last, r3_res_valid, r3_res_ready;
  logic [1:0]      r3_res_tid;
  logic [3*RW-1:0] r3_rslt_data;
  logic [2:0]      r3_rslt_last, r3_rslt_valid, r3_rslt_ready;
  logic [2:0]      r3_grant;
  logic [3:0]      r3_inflight;
  logic            r3_err;

  int total = 0;
  int bad   = 0;

  sech2_lut_arbiter #(.N_REQ(4), .ID_WIDTH(2), .DATA_WIDTH_DATA(DW),
                      .DATA_WIDTH_RSLT(RW), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_req_tdata(req_data), .s_axis_req_tlast(req_last),
    .s_axis_req_tvalid(req_valid), .s_axis_req_tready(req_ready),
    .m_axis_lut_tdata(lut_data), .m_axis_lut_tlast(lut_last), .m_axis_lut_tid(lut_tid),
    .m_axis_lut_tvalid(lut_valid), .m_axis_lut_tready(lut_ready),
    .s_axis_lut_tdata(res_data), .s_axis_lut_tlast(res_last), .s_axis_lut_tid(res_tid),
    .s_axis_lut_tvalid(res_valid), .s_axis_lut_tready(res_ready),
    .m_axis_rslt_tdata(rslt_data), .m_axis_rslt_tlast(rslt_last),
    .m_axis_rslt_tvalid(rslt_valid), .m_axis_rslt_tready(rslt_ready),
    .grant(grant), .inflight(inflight), .err_bad_id(err)
  );

  sech2_lut_arbiter #(.N_REQ(3), .ID_WIDTH(2), .DATA_WIDTH_DATA(DW),
                      .DATA_WIDTH_RSLT(RW), .MAX_INFLIGHT(4)) dut3 (
    .clk(clk), .rstn(rstn),
    .s_axis_req_tdata(r3_req_data), .s_axis_req_tlast(r3_req_last),
    .s_axis_req_tvalid(r3_req_valid), .s_axis_req_tready(r3_req_ready),
    .m_axis_lut_tdata(r3_lut_data), .m_axis_lut_tlast(r3_lut_last), .m_axis_lut_tid(r3_lut_tid),
    .m_axis_lut_tvalid(r3_lut_valid), .m_axis_lut_tready(r3_lut_ready),
    .s_axis_lut_tdata(r3_res_data), .s_axis_lut_tlast(r3_res_last), .s_axis_lut_tid(r3_res_tid),
    .s_axis_lut_tvalid(r3_res_valid), .s_axis_lut_tready(r3_res_ready),
    .m_axis_rslt_tdata(r3_rslt_data), .m_axis_rslt_tlast(r3_rslt_last),
    .m_axis_rslt_tvalid(r3_rslt_valid), .m_axis_rslt_tready(r3_rslt_ready),
    .grant(r3_grant), .inflight(r3_inflight), .err_bad_id(r3_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic l, input logic [DW-1:0] d);
    req_valid[idx] = v;
    req_last[idx]  = l;
    req_data[idx*DW +: DW] = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pkt_word(input int g, input int p, input int b);
    return 16'hA000 | DW'(p << 8) | DW'(g << 4) | DW'(b);
  endfunction

  initial begin
    int order [5];
    int model_inf;
    int g;
    bit ret;
    order = '{0, 1, 2, 3, 0};

    req_data = '0; req_last = '0; req_valid = '0; lut_ready = 1'b1;
    res_data = '0; res_last = 1'b0; res_tid = 2'd1; res_valid = 1'b1;
    rslt_ready = '1;
    r3_req_data = '0; r3_req_last = '0; r3_req_valid = '0; r3_lut_ready = 1'b1;
    r3_res_data = '0; r3_res_last = 1'b0; r3_res_tid = '0; r3_res_valid = 1'b0;
    r3_rslt_ready = '0;

    // Reset state, including result path held off during reset
    #3;
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_inflight", inflight, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_lut_valid", lut_valid, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_res_ready", res_ready, 0);
    checkOutput("rst_rslt_valid", rslt_valid, 0);
    res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;

    // Single requester, 3-beat packet
    applyStimulus(0, 1'b1, 1'b0, 16'h0100);
    #1;
    checkOutput("t1_bubble_grant", grant, 0);
    checkOutput("t1_bubble_valid", lut_valid, 0);
    checkOutput("t1_bubble_ready", req_ready, 0);
    nextCycle();
    checkOutput("t1_grant", grant, 4'b0001);
    checkOutput("t1_valid0", lut_valid, 1);
    checkOutput("t1_tid0", lut_tid, 0);
    checkOutput("t1_data0", lut_data, 16'h0100);
    checkOutput("t1_ready0", req_ready, 4'b0001);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 16'h0200);
    #1;
    checkOutput("t1_inflight1", inflight, 1);
    checkOutput("t1_data1", lut_data, 16'h0200);
    checkOutput("t1_valid1", lut_valid, 1);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 16'h0300);
    #1;
    checkOutput("t1_inflight2", inflight, 2);
    checkOutput("t1_last2", lut_last, 1);
    checkOutput("t1_data2", lut_data, 16'h0300);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 16'h0000);
    #1;
    checkOutput("t1_idle_grant", grant, 0);
    checkOutput("t1_inflight3", inflight, 3);
    checkOutput("t1_idle_valid", lut_valid, 0);
    res_valid = 1'b1; res_tid = 2'd0; res_data = 16'h1111; res_last = 1'b0;
    #1;
    checkOutput("t1_rslt_valid", rslt_valid, 4'b0001);
    checkOutput("t1_rslt_data0", rslt_data[15:0], 16'h1111);
    checkOutput("t1_res_ready", res_ready, 1);
    nextCycle();
    res_data = 16'h2222;
    #1;
    checkOutput("t1_ret_inflight2", inflight, 2);
    nextCycle();
    res_data = 16'h3333; res_last = 1'b1;
    #1;
    checkOutput("t1_rslt_last", rslt_last, 4'b0001);
    checkOutput("t1_ret_inflight1", inflight, 1);
    nextCycle();
    res_valid = 1'b0; res_last = 1'b0; res_data = 16'hDEAD;
    #1;
    checkOutput("t1_ret_inflight0", inflight, 0);
    checkOutput("t1_rslt_idle", rslt_valid, 0);
    checkOutput("t1_rslt_hold", rslt_data[15:0], 16'h3333);
    checkOutput("t1_grant_end", grant, 0);

    // Round robin among four 2-beat packets from reset
    rstn = 1'b0;
    #1 rstn = 1'b1;
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 1'b0, pkt_word(i, i, 0));
    model_inf = 0;
    for (int p = 0; p < 5; p++) begin
      g = order[p];
      ret = (model_inf > 0);
      res_valid = ret; res_tid = 2'd0;
      #1;
      checkOutput("t2_bubble_grant", grant, 0);
      checkOutput("t2_bubble_inflight", inflight, 4'(model_inf));
      nextCycle();
      if (ret) model_inf--;
      for (int b = 0; b < 2; b++) begin
        ret = (model_inf > 0);
        res_valid = ret;
        #1;
        checkOutput("t2_grant", grant, 64'(1 << g));
        checkOutput("t2_tid", lut_tid, 64'(g));
        checkOutput("t2_data", lut_data, pkt_word(g, p, b));
        checkOutput("t2_last", lut_last, 64'(b));
        checkOutput("t2_inflight", inflight, 4'(model_inf));
        nextCycle();
        model_inf = model_inf + 1 - (ret ? 1 : 0);
        if (b == 0) applyStimulus(g, 1'b1, 1'b1, pkt_word(g, p, 1));
        else if (p == 0) applyStimulus(0, 1'b1, 1'b0, pkt_word(0, 4, 0));
        else applyStimulus(g, 1'b0, 1'b0, 16'h0000);
      end
    end
    res_valid = 1'b1;
    nextCycle();
    res_valid = 1'b0;
    #1;
    checkOutput("t2_drained", inflight, 0);

    // In-flight cap with the result path stalled
    rslt_ready = 4'b0000;
    applyStimulus(2, 1'b1, 1'b0, 16'h2001);
    #1;
    checkOutput("t3_bubble_grant", grant, 0);
    nextCycle();
    for (int b = 1; b <= 4; b++) begin
      #1;
      checkOutput("t3_issue_valid", lut_valid, 1);
      checkOutput("t3_issue_inflight", inflight, 4'(b - 1));
      checkOutput("t3_issue_data", lut_data, 16'h2000 + 16'(b));
      nextCycle();
      applyStimulus(2, 1'b1, 1'b0, 16'h2000 + 16'(b + 1));
    end
    #1;
    checkOutput("t3_cap_valid", lut_valid, 0);
    checkOutput("t3_cap_ready", req_ready, 0);
    checkOutput("t3_cap_inflight", inflight, 4);
    checkOutput("t3_cap_grant", grant, 4'b0100);
    res_valid = 1'b1; res_tid = 2'd2; res_data = 16'hBEEF; res_last = 1'b0;
    #1;
    checkOutput("t3_stall_res_ready", res_ready, 0);
    checkOutput("t3_stall_rslt_valid", rslt_valid, 4'b0100);
    nextCycle();
    checkOutput("t3_stall_inflight", inflight, 4);
    rslt_ready = 4'b1111;
    #1;
    checkOutput("t3_release_res_ready", res_ready, 1);
    checkOutput("t3_same_cycle_blocked", lut_valid, 0);
    nextCycle();
    checkOutput("t3_resume_inflight", inflight, 3);
    checkOutput("t3_resume_valid", lut_valid, 1);
    checkOutput("t3_resume_ready", req_ready, 4'b0100);

    // Simultaneous issue and return at inflight 3
    nextCycle();
    applyStimulus(2, 1'b1, 1'b0, 16'h2006);
    #1;
    checkOutput("t4_inflight", inflight, 3);
    checkOutput("t4_next_valid", lut_valid, 1);
    checkOutput("t4_next_data", lut_data, 16'h2006);

    // Requester drops valid mid-packet: lock is held
    applyStimulus(2, 1'b0, 1'b0, 16'h2006);
    #1;
    checkOutput("t4_gap_valid", lut_valid, 0);
    nextCycle();
    res_valid = 1'b0;
    #1;
    checkOutput("t4_gap_inflight", inflight, 2);
    checkOutput("t4_gap_grant", grant, 4'b0100);

    // Reset mid-packet
    applyStimulus(2, 1'b1, 1'b0, 16'h2007);
    applyStimulus(0, 1'b1, 1'b0, 16'h3000);
    res_valid = 1'b1; res_tid = 2'd1;
    rstn = 1'b0;
    #1;
    checkOutput("t6_grant", grant, 0);
    checkOutput("t6_inflight", inflight, 0);
    checkOutput("t6_lut_valid", lut_valid, 0);
    checkOutput("t6_req_ready", req_ready, 0);
    checkOutput("t6_res_ready", res_ready, 0);
    checkOutput("t6_rslt_valid", rslt_valid, 0);
    nextCycle();
    rstn = 1'b1; res_valid = 1'b0;
    #1;
    checkOutput("t6_idle_grant", grant, 0);
    nextCycle();
    checkOutput("t6_first_grant", grant, 4'b0001);
    checkOutput("t6_first_data", lut_data, 16'h3000);
    applyStimulus(0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(2, 1'b0, 1'b0, 16'h0000);

    // Out-of-range result tag on the 3-requester instance
    r3_req_valid[0] = 1'b1; r3_req_last[0] = 1'b1; r3_req_data[15:0] = 16'h0042;
    nextCycle();
    checkOutput("t5_issue_valid", r3_lut_valid, 1);
    nextCycle();
    r3_req_valid = '0;
    #1;
    checkOutput("t5_inflight1", r3_inflight, 1);
    r3_res_valid = 1'b1; r3_res_tid = 2'd3; r3_res_data = 16'h5555;
    #1;
    checkOutput("t5_res_ready", r3_res_ready, 1);
    checkOutput("t5_rslt_valid", r3_rslt_valid, 0);
    checkOutput("t5_err_before", r3_err, 0);
    nextCycle();
    r3_res_valid = 1'b0;
    #1;
    checkOutput("t5_err_set", r3_err, 1);
    checkOutput("t5_inflight0", r3_inflight, 0);
    repeat (3) nextCycle();
    checkOutput("t5_err_sticky", r3_err, 1);
    rstn = 1'b0;
    #1;
    checkOutput("t5_err_reset", r3_err, 0);
    nextCycle();
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
